// File: rtl/stage_pkg.sv
// Shared definitions for the elastic pipeline stage latches: state encodings and
// the default MEM/WB payload layout, so stage wrappers can pack and unpack fields.
package stage_pkg;

    // The encoding is {skid_valid, main_valid}; code 2'b10 is never reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    localparam int WR_ID_W   = 5;
    localparam int FMASK_W   = 8;
    localparam int RESULT_W  = 16;
    localparam int FLAGS_W   = 8;

    localparam int FLAGS_LSB  = 0;
    localparam int RESULT_LSB = FLAGS_LSB + FLAGS_W;
    localparam int FMASK_LSB  = RESULT_LSB + RESULT_W;
    localparam int WR_ID_LSB  = FMASK_LSB + FMASK_W;
    localparam int PAYLOAD_W  = WR_ID_LSB + WR_ID_W;

    localparam int DEBUG_W    = 104;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [WR_ID_W-1:0]  wr_id,
        input logic [FMASK_W-1:0]  fmask,
        input logic [RESULT_W-1:0] result,
        input logic [FLAGS_W-1:0]  flags
    );
        return {wr_id, fmask, result, flags};
    endfunction

endpackage

// File: rtl/stage_payload_reg.sv
// Payload register with asynchronous reset to a configurable value and a load enable.
// Used for the main and skid entries (and their debug shadows) of elastic_stage_latch.
module stage_payload_reg #(
    parameter int           W       = 37,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    // NOTE: payload registers are reset on purpose so out_data shows a known value
    // right after reset; this is a couple of flops, not a RAM array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/elastic_stage_latch.sv
// Valid/ready pipeline stage latch with a 2-entry skid buffer and a registered output.
// Optional debug side-channel when STAGE_DEBUG_EN is defined.
module elastic_stage_latch
    import stage_pkg::*;
#(
    parameter int                DATA_W  = 37,
    parameter logic [DATA_W-1:0] RST_VAL = '0
`ifdef STAGE_DEBUG_EN
    ,
    parameter int                DEBUG_W = stage_pkg::DEBUG_W
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef STAGE_DEBUG_EN
    input  logic [DEBUG_W-1:0] debug_in,
    output logic [DEBUG_W-1:0] debug_out,
`endif
    output logic [1:0]        count
);

    stage_state_e state_d;
    stage_state_e state_q;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] main_in;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    // Upstream ready depends only on registered state and stall, never on out_ready.
    assign in_ready  = !stall && !skid_valid;
    assign out_valid = !stall && main_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!stall) begin
            if (flush) begin
                state_d = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            state_d   = ST_ONE;
                            main_load = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && out_fire) begin
                            main_load = 1'b1;
                        end else if (in_fire) begin
                            state_d   = ST_FULL;
                            skid_load = 1'b1;
                        end else if (out_fire) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (out_fire) begin
                            state_d        = ST_ONE;
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_in = main_from_skid ? skid_data : in_data;

    stage_payload_reg #(.W(DATA_W), .RST_VAL(RST_VAL)) u_main_reg (
        .CLK  (CLK),
        .RST  (RST),
        .load (main_load),
        .d    (main_in),
        .q    (main_data)
    );

    stage_payload_reg #(.W(DATA_W), .RST_VAL(RST_VAL)) u_skid_reg (
        .CLK  (CLK),
        .RST  (RST),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_data)
    );

    assign out_data = main_data;

`ifdef STAGE_DEBUG_EN
    logic [DEBUG_W-1:0] dbg_main;
    logic [DEBUG_W-1:0] dbg_skid;
    logic [DEBUG_W-1:0] dbg_main_in;

    assign dbg_main_in = main_from_skid ? dbg_skid : debug_in;

    stage_payload_reg #(.W(DEBUG_W), .RST_VAL('0)) u_dbg_main_reg (
        .CLK  (CLK),
        .RST  (RST),
        .load (main_load),
        .d    (dbg_main_in),
        .q    (dbg_main)
    );

    stage_payload_reg #(.W(DEBUG_W), .RST_VAL('0)) u_dbg_skid_reg (
        .CLK  (CLK),
        .RST  (RST),
        .load (skid_load),
        .d    (debug_in),
        .q    (dbg_skid)
    );

    assign debug_out = dbg_main;
`endif

endmodule

// File: tb/tb_elastic_stage_latch.sv
// Directed, table-driven bench for elastic_stage_latch; outputs are checked one
// nanosecond after inputs change on the falling edge, before the next rising edge.
module tb_elastic_stage_latch;

    localparam int DATA_W = 37;
`ifdef STAGE_DEBUG_EN
    localparam int DEBUG_W = 104;
    localparam logic [DEBUG_W-1:0] DBG_K = 104'h5A5A_1234_5678_9ABC_DEF0_0F0F_3C;
`endif

    logic              CLK;
    logic              RST;
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;
`ifdef STAGE_DEBUG_EN
    logic [DEBUG_W-1:0] debug_in;
    logic [DEBUG_W-1:0] debug_out;
`endif

    int checks = 0;
    int errors = 0;

    elastic_stage_latch #(.DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef STAGE_DEBUG_EN
        .debug_in  (debug_in),
        .debug_out (debug_out),
`endif
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef STAGE_DEBUG_EN
    assign debug_in = {{(DEBUG_W-DATA_W){1'b0}}, in_data} ^ DBG_K;
`endif

    typedef struct {
        logic        stall;
        logic        flush;
        logic        in_valid;
        logic [7:0]  in_data;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [7:0]  exp_out_data;
        logic [1:0]  exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic f, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic eir, input logic eov,
                       input logic [7:0] eod, input logic [1:0] ec);
        vec_t v;
        v.stall = s; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
        v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_out_data = eod; v.exp_count = ec;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    endtask

    initial begin
        drive_idle();
        RST = 1'b1;
        #1;
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_count",     {62'd0, count},     64'd0);
        check("reset_out_data",  {27'd0, out_data},  64'd0);
        @(negedge CLK);
        RST = 1'b0;

        //  st fl iv data ordy | in_rdy out_v out_d cnt
        // Streaming 01..05 at full rate, one-cycle latency.
        add(0, 0, 1, 8'h01, 1,  1, 0, 8'h00, 0);
        add(0, 0, 1, 8'h02, 1,  1, 1, 8'h01, 1);
        add(0, 0, 1, 8'h03, 1,  1, 1, 8'h02, 1);
        add(0, 0, 1, 8'h04, 1,  1, 1, 8'h03, 1);
        add(0, 0, 1, 8'h05, 1,  1, 1, 8'h04, 1);
        add(0, 0, 0, 8'h00, 1,  1, 1, 8'h05, 1);
        add(0, 0, 0, 8'h00, 1,  1, 0, 8'h05, 0);
        // Backpressure fills the skid; CC offered while full is refused.
        add(0, 0, 1, 8'hAA, 0,  1, 0, 8'h05, 0);
        add(0, 0, 1, 8'hBB, 0,  1, 1, 8'hAA, 1);
        add(0, 0, 1, 8'hCC, 0,  0, 1, 8'hAA, 2);
        add(0, 0, 0, 8'h00, 0,  0, 1, 8'hAA, 2);
        add(0, 0, 0, 8'h00, 1,  0, 1, 8'hAA, 2);
        add(0, 0, 0, 8'h00, 1,  1, 1, 8'hBB, 1);
        add(0, 0, 0, 8'h00, 1,  1, 0, 8'hBB, 0);
        // Stall with flush for three cycles keeps the full buffer intact.
        add(0, 0, 1, 8'hAA, 0,  1, 0, 8'hBB, 0);
        add(0, 0, 1, 8'hBB, 0,  1, 1, 8'hAA, 1);
        add(1, 1, 1, 8'h77, 1,  0, 0, 8'hAA, 2);
        add(1, 1, 1, 8'h77, 1,  0, 0, 8'hAA, 2);
        add(1, 1, 1, 8'h77, 1,  0, 0, 8'hAA, 2);
        add(0, 0, 0, 8'h00, 1,  0, 1, 8'hAA, 2);
        add(0, 0, 0, 8'h00, 1,  1, 1, 8'hBB, 1);
        add(0, 0, 0, 8'h00, 1,  1, 0, 8'hBB, 0);
        // Flush with a simultaneous push: 22 is dropped and never reaches out_data.
        add(0, 0, 1, 8'h11, 0,  1, 0, 8'hBB, 0);
        add(0, 1, 1, 8'h22, 1,  1, 1, 8'h11, 1);
        add(0, 0, 0, 8'h00, 1,  1, 0, 8'h11, 0);
        add(0, 0, 0, 8'h00, 1,  1, 0, 8'h11, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            stall     = vecs[i].stall;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            in_data   = {29'd0, vecs[i].in_data};
            out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].exp_in_ready});
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_out_valid});
            check($sformatf("v%0d_out_data", i),  {27'd0, out_data},  {56'd0, vecs[i].exp_out_data});
            check($sformatf("v%0d_count", i),     {62'd0, count},     {62'd0, vecs[i].exp_count});
`ifdef STAGE_DEBUG_EN
            if (out_valid)
                check($sformatf("v%0d_debug_out", i), debug_out[63:0],
                      {27'd0, out_data} ^ DBG_K[63:0]);
`endif
        end

        // Async reset mid-operation: fill to FULL, then assert RST between edges.
        @(negedge CLK);
        drive_idle(); in_valid = 1'b1; in_data = 37'hAA;
        @(negedge CLK);
        in_data = 37'hBB;
        @(negedge CLK);
        drive_idle();
        #1;
        check("pre_rst_count", {62'd0, count}, 64'd2);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_count",     {62'd0, count},     64'd0);
        check("async_rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("async_rst_out_data",  {27'd0, out_data},  64'd0);
        in_valid = 1'b1; in_data = 37'h33; out_ready = 1'b1;
        @(negedge CLK);
        #1;
        check("rst_held_count",    {62'd0, count},     64'd0);
        check("rst_held_out_data", {27'd0, out_data},  64'd0);
        RST = 1'b0;
        in_data = 37'h44;
        @(negedge CLK);
        drive_idle(); out_ready = 1'b1;
        #1;
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_out_data",  {27'd0, out_data},  64'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
